rx_wb_reader: RTL
=================

RX_WB_READER -- requirements
Module: rx_wb_reader

Interface
REQ-001 SHALL have parameter DEPTH, default 16: output FIFO depth in samples, a power of 2, at least 4.
REQ-002 SHALL have parameter SAMP_W, default 18: width of each reassembled I or Q sample.
REQ-003 SHALL have port adc_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port rx_avail_wb_A, input, 1 bit: one-cycle strobe marking a new wideband sample.
REQ-006 SHALL have port rx_dout_A, input, 16 bits: read data, combinationally selected by rd_getI/rd_getQ/rd_getWB.
REQ-007 SHALL have port rd_getI, output, 1 bit: selects the I low word.
REQ-008 SHALL have port rd_getQ, output, 1 bit: selects the Q low word.
REQ-009 SHALL have port rd_getWB, output, 1 bit: selects the wideband source; tied to 1.
REQ-010 SHALL have port m_valid, output, 1 bit: FIFO not empty.
REQ-011 SHALL have port m_ready, input, 1 bit: consumer accepts the head sample.
REQ-012 SHALL have ports m_i and m_q, outputs, SAMP_W bits each, signed: head I and Q samples.
REQ-013 SHALL have port fifo_level, output, clog2(DEPTH)+1 bits: current FIFO occupancy.
REQ-014 SHALL have port overflow, output, 1 bit: sticky flag, set when a sample is lost.
REQ-015 SHALL have port clear_ovf, input, 1 bit: clears overflow and the overflow counter.

Function
REQ-016 SHALL run a state machine IDLE -> RD_I -> RD_Q -> RD_W -> PUSH -> IDLE; rx_avail_wb_A in IDLE moves it to RD_I on the next cycle.
REQ-017 SHALL drive rd_getI=1 only in RD_I and rd_getQ=1 only in RD_Q (so RD_W reads the packed word), and SHALL capture rx_dout_A at the end of each read state.
REQ-018 SHALL reassemble the captured words as I={W[15:8],Iw[15:6]} and Q={W[7:0],Qw[15:6]}, keeping the sign and dropping the six zero-fill LSBs.
REQ-019 SHALL, in PUSH, write {I,Q} into the FIFO when it is not full; latency from the strobe to m_valid (FIFO previously empty) is 5 cycles.
REQ-020 SHALL, in PUSH with the FIFO full, discard the sample and set overflow.
REQ-021 SHALL ignore a rx_avail_wb_A arriving in any state other than IDLE, and SHALL set overflow when that happens (strobe spacing below 5 cycles).
REQ-022 SHALL pop the FIFO on a cycle where m_valid and m_ready are both 1; m_i/m_q show the head sample (first-word fall-through).
REQ-023 SHALL, when a push and a pop happen in the same cycle on a full FIFO, accept both; overflow is not set and fifo_level is unchanged.
REQ-024 SHALL ignore a pop on an empty FIFO; fifo_level never goes below 0.
REQ-025 SHALL wrap read and write pointers modulo DEPTH.
REQ-026 SHALL give clear_ovf priority over a same-cycle set: the result is overflow=0.

Reset
REQ-027 SHALL, when reset_n=0 on a clock edge, set state=IDLE, empty the FIFO (fifo_level=0, m_valid=0), and clear overflow, rd_getI, rd_getQ and the overflow counter; rd_getWB stays 1.
REQ-028 SHALL, on a reset in the middle of a sequence, abandon the partial sample and never push it.
REQ-029 SHALL hold m_i and m_q at 0 while in reset.

Configuration
REQ-030 SHALL, when RX_WB_READER_OVF_CNT_EN is defined, add output ovf_count[15:0], which counts lost samples, saturates at 16'hFFFF and is cleared by reset_n or clear_ovf.
REQ-031 SHALL, when RX_WB_READER_OVF_CNT_EN is not defined, have no ovf_count port and no counter logic.

Structure
REQ-032 SHALL take the state enumeration, the SAMP_W default and the field positions (high byte, 10-bit low field, 6-bit zero fill) from the shared package kiwi_rx_pkg.
REQ-033 SHALL place the FIFO in the sub-module rx_wb_fifo (synchronous, parameterised by DEPTH and width, first-word fall-through, with a level output).

Verification
REQ-034 SHALL test single sample: I=18'h2ABCD, Q=18'h1F00F presented as I word 16'hF340, Q word 16'h03C0, packed word 16'hAA7C -> m_valid at +5 cycles, m_i=18'h2ABCD, m_q=18'h1F00F.
REQ-035 SHALL test sign: I=-1, Q=-131072 -> m_i=18'h3FFFF, m_q=18'h20000.
REQ-036 SHALL test fill: DEPTH=16 with m_ready=0, 17 strobes spaced 8 cycles apart -> fifo_level=16, overflow=1, ovf_count=1, first 16 samples intact in order.
REQ-037 SHALL test strobe collision: strobes 3 cycles apart -> second strobe dropped, overflow=1, exactly one sample pushed.
REQ-038 SHALL test full plus pop: FIFO full, m_ready=1 in the PUSH cycle -> sample accepted, fifo_level stays 16, overflow=0.
REQ-039 SHALL test reset in RD_Q: reset_n low for 1 cycle -> fifo_level=0, no push, next strobe handled normally.

Source files
------------

// File: rtl/kiwi_rx_pkg.sv
// Shared definitions for the wideband RX reader: read-sequence states and the
// field layout of the I word, Q word and packed high-byte word.
package kiwi_rx_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StRdI,
      StRdQ,
      StRdW,
      StPush
   } rd_state_e;

   localparam int unsigned SampWDefault = 18;

   // High bytes of I and Q share one packed word; low fields sit above a zero fill
   localparam int unsigned HiByteW    = 8;
   localparam int unsigned IHiMsb     = 15;
   localparam int unsigned IHiLsb     = 8;
   localparam int unsigned QHiMsb     = 7;
   localparam int unsigned QHiLsb     = 0;
   localparam int unsigned ZeroFillW  = 6;
   localparam int unsigned LoFieldW   = 10;
   localparam int unsigned LoFieldLsb = ZeroFillW;
   localparam int unsigned LoFieldMsb = ZeroFillW + LoFieldW - 1;
   localparam int unsigned PackedW    = HiByteW + LoFieldW;

   function automatic logic [PackedW-1:0] join_sample(input logic [HiByteW-1:0]  hi,
                                                      input logic [LoFieldW-1:0] lo);
      return {hi, lo};
   endfunction

endpackage

// File: rtl/rx_wb_fifo.sv
// Synchronous first-word fall-through FIFO with occupancy output. A push on a
// full FIFO is accepted when a pop happens in the same cycle.
module rx_wb_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 36
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         data_in,
   input  logic                     pop,
   output logic [WIDTH-1:0]         data_out,
   output logic                     valid,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign valid    = (level != '0);
   assign full     = (level == LW'(DEPTH));
   assign do_pop   = pop && valid;
   assign do_push  = push && (!full || do_pop);
   assign data_out = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= data_in;
      end
   end

   // Pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/rx_wb_reader.sv
// Wideband RX sample reader: reads I, Q and packed words per strobe and queues
// reassembled samples. Define RX_WB_READER_OVF_CNT_EN to add the ovf_count output.
module rx_wb_reader
   import kiwi_rx_pkg::*;
#(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned SAMP_W = SampWDefault
) (
   input  logic                     adc_clk,
   input  logic                     reset_n,
   input  logic                     rx_avail_wb_A,
   input  logic [15:0]              rx_dout_A,
   output logic                     rd_getI,
   output logic                     rd_getQ,
   output logic                     rd_getWB,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic signed [SAMP_W-1:0] m_i,
   output logic signed [SAMP_W-1:0] m_q,
   output logic [$clog2(DEPTH):0]   fifo_level,
   input  logic                     clear_ovf,
`ifdef RX_WB_READER_OVF_CNT_EN
   output logic [15:0]              ovf_count,
`endif
   output logic                     overflow
);

   rd_state_e             state;
   logic [LoFieldW-1:0]   i_field;
   logic [LoFieldW-1:0]   q_field;
   logic [15:0]           w_word;
   logic [PackedW-1:0]    i_raw;
   logic [PackedW-1:0]    q_raw;
   logic signed [SAMP_W-1:0] i_smp;
   logic signed [SAMP_W-1:0] q_smp;
   logic [2*SAMP_W-1:0]   head;
   logic                  push;
   logic                  pop;
   logic                  full;
   logic                  push_lost;
   logic                  strobe_lost;

   assign rd_getWB = 1'b1;

   // rx_dout_A follows rd_getI/rd_getQ, so each read state captures its own word
   always_ff @(posedge adc_clk) begin
      if (!reset_n) begin
         state   <= StIdle;
         rd_getI <= 1'b0;
         rd_getQ <= 1'b0;
         i_field <= '0;
         q_field <= '0;
         w_word  <= '0;
      end else begin
         case (state)
            StIdle: begin
               if (rx_avail_wb_A) begin
                  state   <= StRdI;
                  rd_getI <= 1'b1;
               end
            end
            StRdI: begin
               i_field <= rx_dout_A[LoFieldMsb:LoFieldLsb];
               rd_getI <= 1'b0;
               rd_getQ <= 1'b1;
               state   <= StRdQ;
            end
            StRdQ: begin
               q_field <= rx_dout_A[LoFieldMsb:LoFieldLsb];
               rd_getQ <= 1'b0;
               state   <= StRdW;
            end
            StRdW: begin
               w_word <= rx_dout_A;
               state  <= StPush;
            end
            StPush: begin
               state <= StIdle;
            end
            default: begin
               state   <= StIdle;
               rd_getI <= 1'b0;
               rd_getQ <= 1'b0;
            end
         endcase
      end
   end

   assign i_raw = join_sample(w_word[IHiMsb:IHiLsb], i_field);
   assign q_raw = join_sample(w_word[QHiMsb:QHiLsb], q_field);
   assign i_smp = SAMP_W'(signed'(i_raw));
   assign q_smp = SAMP_W'(signed'(q_raw));

   assign push        = (state == StPush);
   assign pop         = m_valid && m_ready;
   assign push_lost   = push && full && !pop;
   assign strobe_lost = rx_avail_wb_A && (state != StIdle);

   rx_wb_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (2 * SAMP_W)
   ) u_fifo (
      .clk      (adc_clk),
      .reset_n  (reset_n),
      .push     (push),
      .data_in  ({i_smp, q_smp}),
      .pop      (pop),
      .data_out (head),
      .valid    (m_valid),
      .full     (full),
      .level    (fifo_level)
   );

   assign m_i = (reset_n && m_valid) ? head[2*SAMP_W-1:SAMP_W] : '0;
   assign m_q = (reset_n && m_valid) ? head[SAMP_W-1:0]        : '0;

   always_ff @(posedge adc_clk) begin
      if (!reset_n || clear_ovf) begin
         overflow <= 1'b0;
      end else if (push_lost || strobe_lost) begin
         overflow <= 1'b1;
      end
   end

`ifdef RX_WB_READER_OVF_CNT_EN
   logic [16:0] cnt_sum;

   // A dropped strobe and a dropped push can coincide, losing two samples
   assign cnt_sum = {1'b0, ovf_count} + 17'(strobe_lost) + 17'(push_lost);

   always_ff @(posedge adc_clk) begin
      if (!reset_n || clear_ovf) begin
         ovf_count <= '0;
      end else if (strobe_lost || push_lost) begin
         ovf_count <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
      end
   end
`endif

endmodule
